meta_array_sched: RTL and testbench

//  Sequencer/arbiter for one 1R1W metadata SRAM macro (DEPTH x WIDTH, 1-cycle registered-address read).

---
 rtl/meta_array_sched.sv | 134 +++++++++++++
 tb/tb_meta_array_sched.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/meta_array_sched.sv
// meta_array_sched: sequencer/arbiter in front of a 1R1W metadata SRAM macro.
// After reset or flush, every entry is swept to zero. Once the sweep is done,
// two lookup clients share the read port round-robin. The write port is shared
// between refill (wr0) and update (wr1), with refill always taking priority.
module meta_array_sched #(
    parameter int DEPTH = 40,
    parameter int WIDTH = 240,
    parameter int AW    = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [1:0]             rd_valid,
    input  logic [1:0][AW-1:0]     rd_addr,
    output logic [1:0]             rd_ready,
    output logic [1:0]             rd_resp_valid,
    output logic [WIDTH-1:0]       rd_resp_data,
    input  logic [1:0]             wr_valid,
    input  logic [1:0][AW-1:0]     wr_addr,
    input  logic [1:0][WIDTH-1:0]  wr_data,
    output logic [1:0]             wr_ready,
    input  logic                   flush_valid,
    output logic                   flush_ready,
    output logic                   init_done,
    output logic [AW-1:0]          mem_R0_addr,
    output logic                   mem_R0_en,
    input  logic [WIDTH-1:0]       mem_R0_data,
    output logic [AW-1:0]          mem_W0_addr,
    output logic                   mem_W0_en,
    output logic [WIDTH-1:0]       mem_W0_data
);

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t        state;
    logic [AW-1:0] cnt;
    logic          rr_ptr;
    logic [1:0]    resp_valid;
    logic [1:0]    rd_gnt;
    logic          rd_idx;
    logic          wr_idx;

    // Response data is the macro output passed straight through; the valid
    // bits say which requester (if any) owns it.
    assign rd_resp_data  = mem_R0_data;
    assign rd_resp_valid = resp_valid;
    assign init_done     = (state == ST_RUN);

    // Per-cycle port steering: sweep writes in INIT, arbitration in RUN,
    // and nothing at all while reset is held.
    always_comb begin
        rd_ready    = 2'b00;
        wr_ready    = 2'b00;
        flush_ready = 1'b0;
        rd_gnt      = 2'b00;
        rd_idx      = 1'b0;
        wr_idx      = 1'b0;
        mem_R0_en   = 1'b0;
        mem_R0_addr = '0;
        mem_W0_en   = 1'b0;
        mem_W0_addr = '0;
        mem_W0_data = '0;
        if (reset) begin
            rd_gnt = 2'b00;
        end else if (state == ST_INIT) begin
            mem_W0_en   = 1'b1;
            mem_W0_addr = cnt;
        end else if (flush_valid) begin
            flush_ready = 1'b1;
        end else begin
            case (rd_valid)
                2'b01:   rd_idx = 1'b0;
                2'b10:   rd_idx = 1'b1;
                2'b11:   rd_idx = rr_ptr;
                default: rd_idx = 1'b0;
            endcase
            if (rd_valid != 2'b00) begin
                rd_gnt[rd_idx] = 1'b1;
                mem_R0_en      = 1'b1;
                mem_R0_addr    = rd_addr[rd_idx];
            end else begin
                rd_gnt = 2'b00;
            end
            rd_ready = rd_gnt;
            wr_idx   = ~wr_valid[0];
            if (wr_valid != 2'b00) begin
                wr_ready[wr_idx] = 1'b1;
                // Out-of-range writes are acknowledged but never reach the macro.
                mem_W0_en   = (wr_addr[wr_idx] <= LAST);
                mem_W0_addr = wr_addr[wr_idx];
                mem_W0_data = wr_data[wr_idx];
            end else begin
                mem_W0_en = 1'b0;
            end
        end
    end

    // Sweep/run state, sweep counter, round-robin pointer and response valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_INIT;
            cnt        <= '0;
            rr_ptr     <= 1'b0;
            resp_valid <= 2'b00;
        end else begin
            resp_valid <= rd_gnt;
            if (rd_gnt != 2'b00) begin
                rr_ptr <= ~rd_idx;
            end
            case (state)
                ST_INIT: begin
                    if (cnt == LAST) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + {{(AW-1){1'b0}}, 1'b1};
                    end
                end
                ST_RUN: begin
                    if (flush_valid) begin
                        state <= ST_INIT;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= ST_INIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_meta_array_sched.sv
// Self-checking bench for meta_array_sched with a behavioural SRAM macro and
// a scoreboard of expected read responses.
module tb_meta_array_sched;

    localparam int DEPTH = 40;
    localparam int WIDTH = 240;
    localparam int AW    = 6;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic [1:0]            rd_valid = '0;
    logic [1:0][AW-1:0]    rd_addr = '0;
    logic [1:0]            rd_ready;
    logic [1:0]            rd_resp_valid;
    logic [WIDTH-1:0]      rd_resp_data;
    logic [1:0]            wr_valid = '0;
    logic [1:0][AW-1:0]    wr_addr = '0;
    logic [1:0][WIDTH-1:0] wr_data = '0;
    logic [1:0]            wr_ready;
    logic                  flush_valid = 1'b0;
    logic                  flush_ready;
    logic                  init_done;
    logic [AW-1:0]         mem_R0_addr;
    logic                  mem_R0_en;
    logic [WIDTH-1:0]      mem_R0_data;
    logic [AW-1:0]         mem_W0_addr;
    logic                  mem_W0_en;
    logic [WIDTH-1:0]      mem_W0_data;

    meta_array_sched #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
        .clock(clock), .reset(reset),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .flush_valid(flush_valid), .flush_ready(flush_ready), .init_done(init_done),
        .mem_R0_addr(mem_R0_addr), .mem_R0_en(mem_R0_en), .mem_R0_data(mem_R0_data),
        .mem_W0_addr(mem_W0_addr), .mem_W0_en(mem_W0_en), .mem_W0_data(mem_W0_data)
    );

    always #5 clock = ~clock;

    // Behavioural macro: write at the edge, registered read address, write-first.
    logic [WIDTH-1:0] sram [0:(1<<AW)-1];
    logic [AW-1:0]    sram_raddr = '0;
    always @(posedge clock) begin
        if (mem_W0_en) sram[mem_W0_addr] <= mem_W0_data;
        if (mem_R0_en) sram_raddr <= mem_R0_addr;
    end
    assign mem_R0_data = sram[sram_raddr];

    typedef struct {
        logic [1:0]       v;
        logic [WIDTH-1:0] d;
    } resp_t;
    resp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit               m_run = 1'b0;
    int               m_cnt = 0;
    bit               m_rr  = 1'b0;
    logic [WIDTH-1:0] ref_mem [0:DEPTH-1];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] rand_data();
        logic [255:0] t;
        for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom();
        return t[WIDTH-1:0];
    endfunction

    // One clock cycle: inputs are already driven; check at negedge, update model.
    task automatic tick();
        resp_t      e;
        logic [1:0] erd;
        logic [1:0] ewr;
        logic       ef;
        int         g;
        @(negedge clock);
        if (sb.size() > 0) e = sb.pop_front();
        else begin e.v = 2'b00; e.d = '0; end
        check("resp_valid", 256'(rd_resp_valid), 256'(e.v));
        if (e.v != 2'b00) check("resp_data", 256'(rd_resp_data), 256'(e.d));
        erd = 2'b00; ewr = 2'b00; ef = 1'b0;
        if (m_run) begin
            if (flush_valid) ef = 1'b1;
            else begin
                if (rd_valid == 2'b11) erd[m_rr] = 1'b1;
                else erd = rd_valid;
                if (wr_valid[0]) ewr = 2'b01;
                else if (wr_valid[1]) ewr = 2'b10;
            end
        end
        check("rd_ready", 256'(rd_ready), 256'(erd));
        check("wr_ready", 256'(wr_ready), 256'(ewr));
        check("flush_ready", 256'(flush_ready), 256'(ef));
        check("init_done", 256'(init_done), 256'(m_run));
        if (!m_run) begin
            check("sweep_en", 256'(mem_W0_en), 256'(1'b1));
            check("sweep_addr", 256'(mem_W0_addr), 256'(m_cnt));
            check("sweep_data", 256'(mem_W0_data), 256'(0));
            ref_mem[m_cnt] = '0;
        end else if (ewr != 2'b00) begin
            g = ewr[1];
            check("wr_en", 256'(mem_W0_en), 256'(int'(wr_addr[g]) < DEPTH));
            if (int'(wr_addr[g]) < DEPTH) ref_mem[int'(wr_addr[g])] = wr_data[g];
        end
        if (erd != 2'b00) begin
            g    = erd[1];
            e.v  = erd;
            e.d  = ref_mem[int'(rd_addr[g])];
            m_rr = (g == 0);
        end else begin
            e.v = 2'b00; e.d = '0;
        end
        sb.push_back(e);
        if (!m_run) begin
            if (m_cnt == DEPTH - 1) begin m_run = 1'b1; m_cnt = 0; end
            else m_cnt++;
        end else if (ef) begin
            m_run = 1'b0; m_cnt = 0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        rd_valid = 2'b00; wr_valid = 2'b00; flush_valid = 1'b0;
    endtask

    // Assert reset asynchronously, check quiescent outputs, release after an edge.
    task automatic do_reset();
        reset    = 1'b1;
        rd_valid = 2'b11;
        #2;
        check("rst_init_done", 256'(init_done), 256'(0));
        check("rst_w_en", 256'(mem_W0_en), 256'(0));
        check("rst_r_en", 256'(mem_R0_en), 256'(0));
        check("rst_resp", 256'(rd_resp_valid), 256'(0));
        check("rst_rd_ready", 256'(rd_ready), 256'(0));
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle_inputs();
        sb.delete();
        m_run = 1'b0; m_cnt = 0; m_rr = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) sram[i] = rand_data();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 'x;
        #1;
        do_reset();
        // Sweep with readers knocking: nothing may be granted.
        rd_valid = 2'b11; rd_addr[0] = 6'd1; rd_addr[1] = 6'd2;
        wr_valid = 2'b01; flush_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) tick();
        idle_inputs();
        tick();
        // Seed entries 3 and 7 through the update port only.
        wr_valid = 2'b10; wr_addr[1] = 6'd3; wr_data[1] = rand_data(); tick();
        wr_addr[1] = 6'd7; wr_data[1] = rand_data(); tick();
        idle_inputs();
        // Both readers for 6 cycles: grants alternate starting with requester 0.
        rd_valid = 2'b11; rd_addr[0] = 6'd3; rd_addr[1] = 6'd7;
        for (int i = 0; i < 6; i++) tick();
        idle_inputs();
        tick();
        // Refill write then read-back.
        wr_valid = 2'b01; wr_addr[0] = 6'd5; wr_data[0] = {WIDTH/8{8'hA5}}; tick();
        wr_valid = 2'b00; rd_valid = 2'b01; rd_addr[0] = 6'd5; tick();
        idle_inputs(); tick();
        // Write collision: refill first, update next, read in the same cycle.
        wr_valid = 2'b11; wr_addr[0] = 6'd9; wr_addr[1] = 6'd9;
        wr_data[0] = rand_data(); wr_data[1] = rand_data(); tick();
        wr_valid = 2'b10; rd_valid = 2'b10; rd_addr[1] = 6'd9; tick();
        idle_inputs(); rd_valid = 2'b01; rd_addr[0] = 6'd9; tick();
        // Out-of-range write is acked but dropped.
        rd_valid = 2'b00; wr_valid = 2'b01; wr_addr[0] = 6'd50; tick();
        idle_inputs(); tick();
        // Flush with a read in flight.
        rd_valid = 2'b01; rd_addr[0] = 6'd5; tick();
        rd_valid = 2'b11; flush_valid = 1'b1; tick();
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) tick();
        rd_valid = 2'b01; rd_addr[0] = 6'd5; tick();
        rd_valid = 2'b10; rd_addr[1] = 6'd9; tick();
        idle_inputs(); tick();
        // Random mix of reads and writes.
        for (int i = 0; i < 80; i++) begin
            rd_valid   = 2'($urandom_range(0, 3));
            wr_valid   = 2'($urandom_range(0, 3));
            rd_addr[0] = 6'($urandom_range(0, DEPTH - 1));
            rd_addr[1] = 6'($urandom_range(0, DEPTH - 1));
            wr_addr[0] = 6'($urandom_range(0, DEPTH - 1));
            wr_addr[1] = 6'($urandom_range(0, DEPTH - 1));
            wr_data[0] = rand_data();
            wr_data[1] = rand_data();
            tick();
        end
        idle_inputs(); tick();
        // Reset in the middle of a sweep restarts it from address 0.
        flush_valid = 1'b1; tick();
        flush_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        do_reset();
        for (int i = 0; i < DEPTH; i++) tick();
        rd_valid = 2'b01; rd_addr[0] = 6'd7; tick();
        idle_inputs(); tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
